fetch_sequencer: RTL
====================

// Module: fetch_sequencer
// PURPOSE
//  Sequences the PC register and the instruction-memory fetch handshake for the IF stage.
//  Drives the PC's stall/next_pc inputs, issues req/ack fetches at pc_in and buffers returned words into the IF/ID slot.
//  Uses a one-entry skid buffer to absorb decode back-pressure; flushes on EX-stage branch/jump redirects.
// PARAMETERS
//  PC_STEP    4              PC increment per accepted fetch
//  NOP_INSTR  32'h0000_0000  value driven on if_instr when slot empty/flushed
// PORTS
//  clk          in   1   rising-edge clock
//  reset_n      in   1   asynchronous, active-low reset
//  pc_in        in   32  current PC (PC register output)
//  pc_stall     out  1   1 = PC holds; 0 = PC loads next_pc at next edge
//  next_pc      out  32  PC load value
//  imem_req     out  1   fetch request; held until imem_ack
//  imem_addr    out  32  fetch address (= pc_in while imem_req=1)
//  imem_ack     in   1   fetch complete, imem_rdata valid this cycle (ignored when imem_req=0)
//  imem_rdata   in   32  fetched word
//  redirect_valid in 1   taken branch/jump from EX, single-cycle
//  redirect_pc  in   32  redirect target
//  id_stall     in   1   decode cannot accept: IF/ID slot must hold
//  if_valid     out  1   IF/ID slot holds a valid instruction
//  if_pc        out  32  PC of slot instruction
//  if_instr     out  32  slot instruction
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE, imem_req=0, if_valid=0, if_pc=0, if_instr=NOP_INSTR, skid empty,
//   pc_stall=1, next_pc=pc_in. Any outstanding memory transaction is abandoned.
//  States: IDLE, FETCH, SKID, DRAIN. pc_stall/next_pc/imem_req combinational from state+inputs; if_* registered.
//  IDLE: one cycle after reset_n rises -> FETCH. imem_req=0, pc_stall=1.
//  FETCH: imem_req=1, imem_addr=pc_in. imem_ack may assert in the first req cycle (zero-wait memory).
//   - ack & slot free or consumed (!if_valid | !id_stall): load slot {1,pc_in,rdata}; pc_stall=0,
//     next_pc=pc_in+PC_STEP (32-bit wrap); stay FETCH. Throughput 1 instr/cycle.
//   - ack & if_valid & id_stall: capture {pc_in,rdata} into skid; pc_stall=0, next_pc=pc_in+PC_STEP; -> SKID.
//   - no ack: pc_stall=1; slot consumed if !id_stall (if_valid<=0).
//  SKID: imem_req=0, pc_stall=1. When !id_stall: slot<=skid, skid empties, -> FETCH.
//  Redirect (priority over all else, any state except IDLE):
//   - pc_stall=0, next_pc={redirect_pc[31:2],2'b00}; next edge if_valid=0, if_instr=NOP_INSTR, skid cleared.
//   - FETCH with no ack this cycle -> DRAIN; FETCH with ack this cycle -> data discarded, stay FETCH; SKID -> FETCH.
//  DRAIN: imem_req=1 (address held from the outstanding request, not pc_in), pc_stall=1; on ack discard data -> FETCH.
//   A further redirect in DRAIN reloads the PC and stays in DRAIN.
//  imem_req never drops before ack except via reset. imem_addr is stable while imem_req=1.
//  if_valid holds and if_* are stable while id_stall=1, except when cleared by a redirect.
//  No instruction is lost or duplicated; order equals PC order between redirects.
// TESTING
//  1 Zero-wait mem (ack=1), release reset: first if_valid 2 cycles after reset_n rise; if_pc 0,4,8,... one per cycle.
//  2 Ack after 3 wait cycles at pc=0x10: imem_req/addr 0x10 stable 4 cycles, pc_stall=1 for 3; one if_valid, if_pc=0x10.
//  3 Zero-wait, id_stall=1 for 5 cycles: slot holds 0x8, skid holds 0xC, imem_req=0; release -> 0xC, 0x10, ... no loss.
//  4 Outstanding fetch 0x20, redirect to 0x100, ack 2 cycles later: slot flushed, 0x20 data dropped, next req addr 0x100.
//  5 Redirect to 0x103 in same cycle as ack: next_pc=0x100, acked data discarded, next if_pc=0x100.
//  6 reset_n=0 mid-wait: imem_req, if_valid drop immediately (async); restart from IDLE.

Source files
------------

// File: rtl/fetch_sequencer.sv
// IF-stage fetch sequencer: drives PC stall/next_pc, runs the imem req/ack fetch, fills the IF/ID slot.
// Zero-wait memory gives 1 instr/cycle. A one-entry skid absorbs decode stalls. EX redirects flush the slot.
module fetch_sequencer #(
  parameter logic [31:0] PC_STEP   = 32'd4,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] pc_in,
  output logic        pc_stall,
  output logic [31:0] next_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_stall,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);
  typedef enum logic [1:0] {IDLE, FETCH, SKID, DRAIN} state_t;

  state_t      state;
  logic [31:0] drain_addr;
  logic [31:0] skid_pc;
  logic [31:0] skid_instr;
  logic        redirect;
  logic        unused_redirect_lsbs;

  assign redirect             = redirect_valid && (state != IDLE);
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  always_comb begin
    imem_req  = (state == FETCH) || (state == DRAIN);
    // A redirected request keeps its original address until memory answers.
    imem_addr = (state == DRAIN) ? drain_addr : pc_in;
    pc_stall  = 1'b1;
    next_pc   = pc_in;
    if (redirect) begin
      pc_stall = 1'b0;
      next_pc  = {redirect_pc[31:2], 2'b00};
    end else if ((state == FETCH) && imem_ack) begin
      pc_stall = 1'b0;
      next_pc  = pc_in + PC_STEP;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      if_valid   <= 1'b0;
      if_pc      <= 32'd0;
      if_instr   <= NOP_INSTR;
      skid_pc    <= 32'd0;
      skid_instr <= NOP_INSTR;
      drain_addr <= 32'd0;
    end else if (redirect) begin
      if_valid   <= 1'b0;
      if_instr   <= NOP_INSTR;
      skid_pc    <= 32'd0;
      skid_instr <= NOP_INSTR;
      // An unanswered request must still be drained; its data is dropped.
      state      <= (imem_req && !imem_ack) ? DRAIN : FETCH;
      if (state == FETCH) drain_addr <= pc_in;
    end else begin
      case (state)
        IDLE: state <= FETCH;
        FETCH: begin
          if (imem_ack) begin
            if (!if_valid || !id_stall) begin
              if_valid <= 1'b1;
              if_pc    <= pc_in;
              if_instr <= imem_rdata;
            end else begin
              skid_pc    <= pc_in;
              skid_instr <= imem_rdata;
              state      <= SKID;
            end
          end else if (!id_stall) begin
            if_valid <= 1'b0;
            if_instr <= NOP_INSTR;
          end
        end
        SKID: begin
          if (!id_stall) begin
            if_pc    <= skid_pc;
            if_instr <= skid_instr;
            state    <= FETCH;
          end
        end
        DRAIN: if (imem_ack) state <= FETCH;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
